// File: rtl/logs_tick_scheduler.sv
// -----------------------------------------------------------------------------
// logs_tick_scheduler
//
// Multi-channel tick scheduler. Each of NCH channels counts base ticks from
// the shared clock divider against its own programmed period and fires either
// periodically or once. Each firing raises a one-cycle ch_tick pulse and a
// pending event. Pending events are handed to a single consumer, one at a
// time, through a round-robin valid/ready port.
//
// Ports:
//   clk        - clock
//   reset_n    - asynchronous reset, active low
//   base_tick  - one-cycle prescaler pulse from the divider
//   cfg_valid  - configuration request
//   cfg_ready  - configuration accept (low on base_tick cycles)
//   cfg_ch     - target channel of the configuration request
//   cfg_op     - 00 stop, 01 start periodic, 10 start one-shot, 11 set period
//   cfg_data   - period value, used by the set-period operation only
//   ch_tick    - one-cycle fire pulse per channel
//   ch_active  - channel running
//   evt_valid  - event available to the consumer
//   evt_ch     - channel of the presented event
//   evt_ready  - consumer accepts the presented event
//   overrun    - sticky: channel fired while its event was still pending
// -----------------------------------------------------------------------------
module logs_tick_scheduler #(
    parameter  int NCH = 4,
    parameter  int PW  = 8,
    localparam int CW  = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          base_tick,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [1:0]    cfg_op,
    input  logic [PW-1:0] cfg_data,
    output logic [NCH-1:0] ch_tick,
    output logic [NCH-1:0] ch_active,
    output logic          evt_valid,
    output logic [CW-1:0] evt_ch,
    input  logic          evt_ready,
    output logic [NCH-1:0] overrun
);

    localparam logic [1:0]    OP_STOP  = 2'b00;
    localparam logic [1:0]    OP_PER   = 2'b01;
    localparam logic [1:0]    OP_ONE   = 2'b10;
    localparam logic [1:0]    OP_SET   = 2'b11;
    localparam logic [PW-1:0] PER_ZERO = PW'(0);
    localparam logic [PW-1:0] PER_ONE  = PW'(1);
    localparam logic [CW:0]   NCH_W    = (CW+1)'(NCH);

    // Per-channel state
    logic [PW-1:0]  period_r [NCH];
    logic [PW-1:0]  count_r  [NCH];
    logic [NCH-1:0] oneshot_r;
    logic [NCH-1:0] active_r;
    logic [NCH-1:0] pending_r;
    logic [NCH-1:0] overrun_r;
    logic [NCH-1:0] tick_r;

    // Event port state
    logic           evt_valid_r;
    logic [CW-1:0]  evt_ch_r;
    logic [CW-1:0]  ptr_r;

    // Combinational helpers
    logic           cfg_fire_s;
    logic [NCH-1:0] cfg_sel_s;
    logic [NCH-1:0] fire_s;
    logic           grant_hit_s;
    logic           grant_en_s;
    logic [CW-1:0]  grant_idx_s;
    logic [NCH-1:0] grant_oh_s;
    logic [CW-1:0]  ptr_next_s;

    // Config is refused on base_tick cycles so it never races the countdown.
    assign cfg_ready  = ~base_tick;
    assign cfg_fire_s = cfg_valid & ~base_tick;

    assign ch_tick   = tick_r;
    assign ch_active = active_r;
    assign overrun   = overrun_r;
    assign evt_valid = evt_valid_r;
    assign evt_ch    = evt_ch_r;

    // Decode the accepted config target and detect which channels fire now.
    always_comb begin
        cfg_sel_s = '0;
        fire_s    = '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_sel_s[i] = cfg_fire_s && (cfg_ch == CW'(i));
            fire_s[i]    = base_tick && active_r[i] && (count_r[i] == PER_ONE);
        end
    end

    // Round-robin search: first pending bit at or after the pointer, wrapping.
    always_comb begin
        logic [CW:0] idx_v;
        logic        pend_v;
        grant_hit_s = 1'b0;
        grant_idx_s = '0;
        for (int k = 0; k < NCH; k++) begin
            idx_v = {1'b0, ptr_r} + (CW+1)'(k);
            if (idx_v >= NCH_W) begin
                idx_v = idx_v - NCH_W;
            end else begin
                idx_v = idx_v;
            end
            pend_v      = pending_r[idx_v[CW-1:0]] && !grant_hit_s;
            grant_idx_s = pend_v ? idx_v[CW-1:0] : grant_idx_s;
            grant_hit_s = grant_hit_s | pend_v;
        end
    end

    // A new grant is only made while the port is idle; derive its one-hot
    // clear mask and the pointer that follows the granted channel.
    always_comb begin
        logic [CW:0] nxt_v;
        grant_en_s = grant_hit_s && !evt_valid_r;
        grant_oh_s = '0;
        for (int i = 0; i < NCH; i++) begin
            grant_oh_s[i] = grant_en_s && (grant_idx_s == CW'(i));
        end
        nxt_v = {1'b0, grant_idx_s} + (CW+1)'(1);
        if (nxt_v >= NCH_W) begin
            nxt_v = nxt_v - NCH_W;
        end else begin
            nxt_v = nxt_v;
        end
        ptr_next_s = nxt_v[CW-1:0];
    end

    // Channel configuration, countdown, firing and pending/overrun tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                period_r[i] <= PER_ZERO;
                count_r[i]  <= PER_ZERO;
            end
            oneshot_r <= '0;
            active_r  <= '0;
            pending_r <= '0;
            overrun_r <= '0;
            tick_r    <= '0;
        end else begin
            tick_r <= fire_s;
            for (int i = 0; i < NCH; i++) begin
                // Config and firing are mutually exclusive: firing needs
                // base_tick, config needs its absence.
                if (cfg_sel_s[i]) begin
                    case (cfg_op)
                        OP_SET: begin
                            period_r[i] <= cfg_data;
                        end
                        OP_PER, OP_ONE: begin
                            // A zero period cannot count; such a start is dropped.
                            if (period_r[i] != PER_ZERO) begin
                                count_r[i]   <= period_r[i];
                                oneshot_r[i] <= (cfg_op == OP_ONE);
                                active_r[i]  <= 1'b1;
                                overrun_r[i] <= 1'b0;
                            end
                        end
                        OP_STOP: begin
                            active_r[i] <= 1'b0;
                        end
                        default: begin
                            active_r[i] <= active_r[i];
                        end
                    endcase
                end else if (fire_s[i]) begin
                    if (oneshot_r[i]) begin
                        active_r[i] <= 1'b0;
                    end else begin
                        count_r[i] <= period_r[i];
                    end
                    if (pending_r[i]) begin
                        overrun_r[i] <= 1'b1;
                    end
                end else if (base_tick && active_r[i]) begin
                    count_r[i] <= count_r[i] - PER_ONE;
                end
                // A fire in the same cycle as the grant re-arms the bit.
                pending_r[i] <= fire_s[i] | (pending_r[i] & ~grant_oh_s[i]);
            end
        end
    end

    // Event presentation: grant when idle, hold until the consumer accepts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid_r <= 1'b0;
            evt_ch_r    <= '0;
            ptr_r       <= '0;
        end else if (grant_en_s) begin
            evt_valid_r <= 1'b1;
            evt_ch_r    <= grant_idx_s;
            ptr_r       <= ptr_next_s;
        end else if (evt_valid_r && evt_ready) begin
            evt_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logs_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_logs_tick_scheduler
//
// Directed bench for logs_tick_scheduler (NCH=4, PW=8). Inputs change #1
// after the rising edge; outputs are read at that point or at the falling
// edge. A falling-edge monitor counts ch_tick pulses and logs every accepted
// event channel.
// -----------------------------------------------------------------------------
module tb_logs_tick_scheduler;

    localparam int NCH = 4;
    localparam int PW  = 8;
    localparam int CW  = 2;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_PER  = 2'b01;
    localparam logic [1:0] OP_ONE  = 2'b10;
    localparam logic [1:0] OP_SET  = 2'b11;

    logic           clk;
    logic           reset_n;
    logic           base_tick;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch;
    logic [1:0]     cfg_op;
    logic [PW-1:0]  cfg_data;
    logic [NCH-1:0] ch_tick;
    logic [NCH-1:0] ch_active;
    logic           evt_valid;
    logic [CW-1:0]  evt_ch;
    logic           evt_ready;
    logic [NCH-1:0] overrun;

    int n_vec  = 0;
    int n_miss = 0;

    int tick_cnt [NCH];
    int evq [$];

    logs_tick_scheduler #(.NCH(NCH), .PW(PW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .base_tick (base_tick),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_op    (cfg_op),
        .cfg_data  (cfg_data),
        .ch_tick   (ch_tick),
        .ch_active (ch_active),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ready (evt_ready),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NCH; i++) tick_cnt[i] = 0;
    end

    // Count fire pulses and log accepted events at the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (ch_tick[i]) tick_cnt[i] = tick_cnt[i] + 1;
        end
        if (evt_valid && evt_ready) evq.push_back(int'(evt_ch));
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input logic [1:0] op, input int data);
        cfg_valid = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_op    = op;
        cfg_data  = PW'(data);
        step();
        cfg_valid = 1'b0;
    endtask

    // One base tick, then three idle clocks; t is ch_tick right after the tick edge.
    task automatic do_tick(output logic [NCH-1:0] t);
        base_tick = 1'b1;
        step();
        base_tick = 1'b0;
        t = ch_tick;
        repeat (3) step();
    endtask

    initial begin
        logic [NCH-1:0] t;
        int             ev0;
        int             tk0;
        int             budget;

        reset_n   = 1'b0;
        base_tick = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_op    = 2'b00;
        cfg_data  = '0;
        evt_ready = 1'b1;
        repeat (3) step();

        // Reset state
        check_vec("rst_tick",    32'(ch_tick),   32'h0);
        check_vec("rst_active",  32'(ch_active), 32'h0);
        check_vec("rst_evt_vld", 32'(evt_valid), 32'h0);
        check_vec("rst_evt_ch",  32'(evt_ch),    32'h0);
        check_vec("rst_overrun", 32'(overrun),   32'h0);
        reset_n = 1'b1;
        step();

        // Test 1: ch0 period 3 periodic, fires on ticks 3, 6, 9
        cfg(0, OP_SET, 3);
        cfg(0, OP_PER, 0);
        check_vec("t1_active", 32'(ch_active), 32'h1);
        ev0 = evq.size();
        for (int i = 0; i < 9; i++) begin
            do_tick(t);
            check_vec($sformatf("t1_tick%0d", i + 1), 32'(t), (i % 3 == 2) ? 32'h1 : 32'h0);
        end
        check_vec("t1_nevt", 32'(evq.size() - ev0), 32'd3);
        for (int i = ev0; i < evq.size(); i++) begin
            check_vec($sformatf("t1_evch%0d", i - ev0), 32'(evq[i]), 32'd0);
        end
        check_vec("t1_overrun", 32'(overrun), 32'h0);

        // Test 2: ch1 period 2 one-shot, one fire only
        cfg(0, OP_STOP, 0);
        cfg(1, OP_SET, 2);
        cfg(1, OP_ONE, 0);
        tk0 = tick_cnt[1];
        ev0 = evq.size();
        do_tick(t);
        check_vec("t2_tick1", 32'(t), 32'h0);
        do_tick(t);
        check_vec("t2_tick2", 32'(t), 32'h2);
        check_vec("t2_active", 32'(ch_active), 32'h0);
        for (int i = 0; i < 10; i++) do_tick(t);
        check_vec("t2_nticks", 32'(tick_cnt[1] - tk0), 32'd1);
        check_vec("t2_nevt", 32'(evq.size() - ev0), 32'd1);
        check_vec("t2_evch", 32'(evq[evq.size() - 1]), 32'd1);

        // Test 3: all channels period 1, consumer stalled. Two back-to-back
        // base ticks, so the second fire sees every pending bit still set.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        for (int c = 0; c < NCH; c++) cfg(c, OP_SET, 1);
        for (int c = 0; c < NCH; c++) cfg(c, OP_PER, 0);
        evt_ready = 1'b0;
        base_tick = 1'b1;
        step();
        check_vec("t3_tick_a", 32'(ch_tick), 32'hF);
        step();
        base_tick = 1'b0;
        check_vec("t3_overrun", 32'(overrun),   32'hF);
        check_vec("t3_evt_vld", 32'(evt_valid), 32'h1);
        check_vec("t3_evt_ch",  32'(evt_ch),    32'h0);
        repeat (3) step();
        for (int c = 0; c < NCH; c++) cfg(c, OP_STOP, 0);
        check_vec("t3_hold_vld", 32'(evt_valid), 32'h1);
        check_vec("t3_hold_ch",  32'(evt_ch),    32'h0);
        ev0 = evq.size();
        evt_ready = 1'b1;
        budget = 0;
        while (evq.size() < ev0 + 5 && budget < 60) begin
            step();
            budget++;
        end
        check_vec("t3_drain_n", 32'(evq.size() - ev0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (ev0 + i < evq.size())
                check_vec($sformatf("t3_order%0d", i), 32'(evq[ev0 + i]), 32'(i % NCH));
        end
        repeat (3) step();
        check_vec("t3_idle", 32'(evt_valid), 32'h0);

        // Test 4: config during base_tick is refused, accepted next cycle
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        cfg(2, OP_SET, 2);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_op    = OP_PER;
        base_tick = 1'b1;
        #1;
        check_vec("t4_rdy_low", 32'(cfg_ready), 32'h0);
        step();
        base_tick = 1'b0;
        #1;
        check_vec("t4_no_start", 32'(ch_active), 32'h0);
        check_vec("t4_rdy_high", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check_vec("t4_started", 32'(ch_active), 32'h4);

        // Test 5: zero-period start ignored; period change applies at reload
        cfg(3, OP_PER, 0);
        check_vec("t5_zero_per", 32'(ch_active), 32'h4);
        cfg(2, OP_SET, 5);
        for (int i = 0; i < 12; i++) begin
            do_tick(t);
            check_vec($sformatf("t5_tick%0d", i + 1), 32'(t),
                      (i == 1 || i == 6 || i == 11) ? 32'h4 : 32'h0);
        end

        // Test 6: asynchronous reset with an event on the port
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) do_tick(t);
        check_vec("t6_pre_vld", 32'(evt_valid), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("t6_rst_vld",    32'(evt_valid), 32'h0);
        check_vec("t6_rst_active", 32'(ch_active), 32'h0);
        check_vec("t6_rst_tick",   32'(ch_tick),   32'h0);
        check_vec("t6_rst_ovr",    32'(overrun),   32'h0);
        step();
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        ev0 = evq.size();
        tk0 = tick_cnt[2];
        for (int i = 0; i < 8; i++) do_tick(t);
        check_vec("t6_no_evt",  32'(evq.size() - ev0),  32'd0);
        check_vec("t6_no_tick", 32'(tick_cnt[2] - tk0), 32'd0);
        check_vec("t6_active",  32'(ch_active),         32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
